// File: rtl/regfile_wb_queue_if.sv
// Bundle of the two producer channels, the register-file write port,
// the snooped read addresses with their forwarding results, and the
// occupancy status of the writeback queue.
interface regfile_wb_queue_if #(
    parameter int ADSize = 5,
    parameter int DASize = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADSize-1:0] alu_addr;
    logic [DASize-1:0] alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADSize-1:0] lsu_addr;
    logic [DASize-1:0] lsu_data;

    logic              Write;
    logic [ADSize-1:0] Write_ADDR;
    logic [DASize-1:0] DIN;

    logic [ADSize-1:0] Read_ADDR_1;
    logic [ADSize-1:0] Read_ADDR_2;
    logic              fwd_hit_1;
    logic              fwd_hit_2;
    logic [DASize-1:0] fwd_data_1;
    logic [DASize-1:0] fwd_data_2;

    logic [CW-1:0]     count;
    logic              empty;

    // Queue side.
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        input  Read_ADDR_1, Read_ADDR_2,
        output alu_ready, lsu_ready,
        output Write, Write_ADDR, DIN,
        output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
        output count, empty
    );

    // Producer / register-file side.
    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        output Read_ADDR_1, Read_ADDR_2,
        input  alu_ready, lsu_ready,
        input  Write, Write_ADDR, DIN,
        input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
        input  count, empty
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the single register-file write port.
// Accepts ALU and LSU results, keeps them in program order in a small
// FIFO, drains one entry per cycle, and forwards still-pending data to
// the two register-file read addresses.
module regfile_wb_queue #(
    parameter int ADSize = 5,
    parameter int DASize = 32,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADSize-1:0] addr;
        logic [DASize-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          empty;
    logic          pop;
    logic          lsu_push;
    logic          alu_push;
    logic [PW-1:0] alu_slot;

    logic              hit_1, hit_2;
    logic [DASize-1:0] data_1, data_2;

    assign empty = (count == '0);
    assign pop   = !empty;

    // The entry leaving this cycle frees its slot for an incoming push.
    assign free = CW'(DEPTH) - count + CW'(pop);

    // LSU has fixed priority when only one slot is available.
    assign bus.lsu_ready = (free >= CW'(1));
    assign bus.alu_ready = (free >= CW'(2));

    assign lsu_push = bus.lsu_valid && bus.lsu_ready;
    assign alu_push = bus.alu_valid && bus.alu_ready;

    // The LSU entry is the older one when both push together.
    assign alu_slot = tail + PW'(lsu_push);

    assign bus.Write      = pop;
    assign bus.Write_ADDR = pop ? mem[head].addr : '0;
    assign bus.DIN        = pop ? mem[head].data : '0;
    assign bus.count      = count;
    assign bus.empty      = empty;

    // Forwarding search, oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        idx    = '0;
        hit_1  = 1'b0;
        hit_2  = 1'b0;
        data_1 = '0;
        data_2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if (mem[idx].addr == bus.Read_ADDR_1) begin
                    hit_1  = 1'b1;
                    data_1 = mem[idx].data;
                end
                if (mem[idx].addr == bus.Read_ADDR_2) begin
                    hit_2  = 1'b1;
                    data_2 = mem[idx].data;
                end
            end
        end
    end

    assign bus.fwd_hit_1  = hit_1;
    assign bus.fwd_hit_2  = hit_2;
    assign bus.fwd_data_1 = data_1;
    assign bus.fwd_data_2 = data_2;

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: storage is small and must read back as cleared after reset, so it is reset here; large RAMs normally are not.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            if (lsu_push) begin
                mem[tail] <= '{addr: bus.lsu_addr, data: bus.lsu_data};
            end
            if (alu_push) begin
                mem[alu_slot] <= '{addr: bus.alu_addr, data: bus.alu_data};
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            tail  <= tail + PW'(lsu_push) + PW'(alu_push);
            count <= count + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: a queue-based model checked against the
// outputs every cycle, plus directed scenarios with literal expectations.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_wb_queue_if #(.ADSize(5), .DASize(32), .DEPTH(DEPTH)) bus ();

    regfile_wb_queue #(.ADSize(5), .DASize(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    ent_t        q[$];      // model contents, oldest first
    ent_t        wlog[$];   // writes observed on the register-file port
    logic [31:0] rf [32];   // register file fed by the observed writes

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_free();
        return (q.size() == 0) ? DEPTH : DEPTH - q.size() + 1;
    endfunction

    function automatic logic fwd_hit(input logic [4:0] a);
        logic h = 1'b0;
        foreach (q[i]) if (q[i].addr == a) h = 1'b1;
        return h;
    endfunction

    function automatic logic [31:0] fwd_data(input logic [4:0] a);
        logic [31:0] d = '0;
        foreach (q[i]) if (q[i].addr == a) d = q[i].data;
        return d;
    endfunction

    task automatic model_step();
        int   f  = model_free();
        logic lp = bus.lsu_valid && (f >= 1);
        logic ap = bus.alu_valid && (f >= 2);
        if (q.size() > 0) void'(q.pop_front());
        if (lp) q.push_back('{bus.lsu_addr, bus.lsu_data});
        if (ap) q.push_back('{bus.alu_addr, bus.alu_data});
    endtask

    // Model update on each edge; reset empties it immediately.
    always @(posedge clk or posedge rst) begin
        if (rst) q.delete();
        else     model_step();
    end

    // Register-file stand-in capturing what the queue writes.
    always @(posedge clk) begin
        if (!rst && bus.Write) begin
            wlog.push_back('{bus.Write_ADDR, bus.DIN});
            rf[bus.Write_ADDR] <= bus.DIN;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("count",      32'(bus.count),      32'(q.size()));
        check("empty",      32'(bus.empty),      32'(q.size() == 0));
        check("write",      32'(bus.Write),      32'(q.size() != 0));
        check("write_addr", 32'(bus.Write_ADDR), (q.size() != 0) ? 32'(q[0].addr) : 32'd0);
        check("din",        bus.DIN,             (q.size() != 0) ? q[0].data : 32'd0);
        check("alu_ready",  32'(bus.alu_ready),  32'(model_free() >= 2));
        check("lsu_ready",  32'(bus.lsu_ready),  32'(model_free() >= 1));
        check("fwd_hit_1",  32'(bus.fwd_hit_1),  32'(fwd_hit(bus.Read_ADDR_1)));
        check("fwd_hit_2",  32'(bus.fwd_hit_2),  32'(fwd_hit(bus.Read_ADDR_2)));
        check("fwd_data_1", bus.fwd_data_1,      fwd_data(bus.Read_ADDR_1));
        check("fwd_data_2", bus.fwd_data_2,      fwd_data(bus.Read_ADDR_2));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.lsu_valid = v;
        bus.lsu_addr  = a;
        bus.lsu_data  = d;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_addr  = a;
        bus.alu_data  = d;
    endtask

    initial begin
        ent_t exp_q[$];
        set_lsu(1'b0, 5'd0, 32'd0);
        set_alu(1'b0, 5'd0, 32'd0);
        bus.Read_ADDR_1 = 5'd0;
        bus.Read_ADDR_2 = 5'd0;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset and idle values.
        repeat (2) step();
        rst = 1'b0;
        step();
        check("idle_write",     32'(bus.Write),     32'd0);
        check("idle_count",     32'(bus.count),     32'd0);
        check("idle_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("idle_lsu_ready", 32'(bus.lsu_ready), 32'd1);

        // Single ALU push: visible the cycle after acceptance, for one cycle.
        wlog.delete();
        set_alu(1'b1, 5'd3, 32'h4);
        step();
        set_alu(1'b0, 5'd0, 32'd0);
        check("single_write", 32'(bus.Write),      32'd1);
        check("single_addr",  32'(bus.Write_ADDR), 32'd3);
        check("single_din",   bus.DIN,             32'h4);
        step();
        check("single_done",  32'(bus.Write),      32'd0);
        step();
        check("single_nwr",   32'(wlog.size()),    32'd1);
        check("single_rf3",   rf[3],               32'h4);

        // Dual push into empty queue: LSU entry first.
        wlog.delete();
        set_lsu(1'b1, 5'd1, 32'h2);
        set_alu(1'b1, 5'd2, 32'h3);
        step();
        set_lsu(1'b0, 5'd0, 32'd0);
        set_alu(1'b0, 5'd0, 32'd0);
        check("dual_first",  32'(bus.Write_ADDR), 32'd1);
        check("dual_count",  32'(bus.count),      32'd2);
        step();
        check("dual_second", 32'(bus.Write_ADDR), 32'd2);
        check("dual_din2",   bus.DIN,             32'h3);
        repeat (2) step();
        check("dual_nwr",    32'(wlog.size()),    32'd2);

        // Full arbitration: both valid every cycle.
        wlog.delete();
        for (int k = 0; k < 6; k++) begin
            set_lsu(1'b1, 5'(k + 8),  32'h100 + 32'(k));
            set_alu(1'b1, 5'(k + 16), 32'h200 + 32'(k));
            step();
            if (k == 2) begin
                check("full_count",     32'(bus.count),     32'd4);
                check("full_alu_ready", 32'(bus.alu_ready), 32'd0);
                check("full_lsu_ready", 32'(bus.lsu_ready), 32'd1);
            end
        end
        check("full_count_hold", 32'(bus.count), 32'd4);
        set_lsu(1'b0, 5'd0, 32'd0);
        set_alu(1'b0, 5'd0, 32'd0);
        repeat (6) step();
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back('{5'(k + 8), 32'h100 + 32'(k)});
            if (k < 3) exp_q.push_back('{5'(k + 16), 32'h200 + 32'(k)});
        end
        check("full_nwr", 32'(wlog.size()), 32'd9);
        for (int i = 0; i < 9 && i < wlog.size(); i++) begin
            check("full_order_addr", 32'(wlog[i].addr), 32'(exp_q[i].addr));
            check("full_order_data", wlog[i].data,      exp_q[i].data);
        end

        // Forwarding: two entries to r5, youngest returned.
        bus.Read_ADDR_1 = 5'd5;
        bus.Read_ADDR_2 = 5'd6;
        set_lsu(1'b1, 5'd5, 32'hA);
        set_alu(1'b1, 5'd5, 32'hB);
        step();
        set_lsu(1'b0, 5'd0, 32'd0);
        set_alu(1'b0, 5'd0, 32'd0);
        check("fwd_hit1",   32'(bus.fwd_hit_1), 32'd1);
        check("fwd_data1",  bus.fwd_data_1,     32'hB);
        check("fwd_hit2",   32'(bus.fwd_hit_2), 32'd0);
        check("fwd_data2",  bus.fwd_data_2,     32'd0);
        step();
        check("fwd_head_hit",  32'(bus.fwd_hit_1), 32'd1);
        check("fwd_head_data", bus.fwd_data_1,     32'hB);
        step();
        check("fwd_drained", 32'(bus.fwd_hit_1), 32'd0);

        // Wrap-around: ten entries with occasional gaps.
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            set_alu(1'b1, 5'(i), 32'(i + 1));
            step();
            set_alu(1'b0, 5'd0, 32'd0);
            if (i % 3 == 2) step();
        end
        repeat (3) step();
        check("wrap_nwr", 32'(wlog.size()), 32'd10);
        for (int i = 0; i < 10 && i < wlog.size(); i++) begin
            check("wrap_addr", 32'(wlog[i].addr), 32'(i));
            check("wrap_data", wlog[i].data,      32'(i + 1));
        end

        // Reset mid-run with three entries queued.
        set_lsu(1'b1, 5'd20, 32'h20);
        set_alu(1'b1, 5'd21, 32'h21);
        step();
        set_lsu(1'b1, 5'd22, 32'h22);
        set_alu(1'b1, 5'd23, 32'h23);
        step();
        set_lsu(1'b0, 5'd0, 32'd0);
        set_alu(1'b0, 5'd0, 32'd0);
        check("rst_pre_count", 32'(bus.count), 32'd3);
        rst = 1'b1;
        wlog.delete();
        #1;
        check("rst_write",     32'(bus.Write),     32'd0);
        check("rst_count",     32'(bus.count),     32'd0);
        check("rst_empty",     32'(bus.empty),     32'd1);
        check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("rst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        step();
        rst = 1'b0;
        repeat (3) step();
        check("rst_no_writes", 32'(wlog.size()), 32'd0);
        check("rst_count_after", 32'(bus.count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback queue feeding the single write port of the 32×32 register file. It accepts results from two producers, the ALU and the load/store unit, through valid/ready handshakes. It buffers them in a small in-order FIFO and drains one entry per cycle onto the register file's `Write`/`Write_ADDR`/`DIN` port. It also forwards pending (not yet written) data to the register file's two read addresses so the decode stage never reads a stale value.

## Interface
- `ADSize`, 5: register address width
- `DASize`, 32: data width
- `DEPTH`, 4: FIFO entries (power of two, ≥2)

Ports:
- `clk` in 1: clock; all state updates on the rising edge
- `rst` in 1: reset, asynchronous, active-high
- `alu_valid` in 1: ALU result valid
- `alu_ready` out 1: ALU result accepted this cycle when high together with `alu_valid`
- `alu_addr` in ADSize: ALU destination register
- `alu_data` in DASize: ALU result
- `lsu_valid`, `lsu_ready`, `lsu_addr`, `lsu_data`: same as the ALU channel, for the LSU
- `Write` out 1: register file write enable
- `Write_ADDR` out ADSize: register file write address
- `DIN` out DASize: register file write data
- `Read_ADDR_1`, `Read_ADDR_2` in ADSize: the register file's read addresses (snooped)
- `fwd_hit_1`, `fwd_hit_2` out 1: a pending entry matches the corresponding read address
- `fwd_data_1`, `fwd_data_2` out DASize: data of the youngest matching entry; 0 when no hit
- `count` out log2(DEPTH)+1: occupied entries
- `empty` out 1: count == 0

## Operation
- The FIFO stores {addr, data} with head/tail pointers that wrap modulo DEPTH, plus a registered `count`.
- Drain:
  - `Write` = !empty; `Write_ADDR`/`DIN` = head entry.
  - Both are forced to 0 when empty.
  - The head pops on every rising edge where `Write` is 1.
- Free slots this cycle: `free = DEPTH - count + (empty ? 0 : 1)`. The pop in the same cycle counts as space.
- Arbitration:
  - free ≥ 2: both ready high.
  - free == 1: `lsu_ready`=1, `alu_ready`=0 (LSU fixed priority).
  - free == 0: both 0.
- Ready signals are combinational from `count` only and do not depend on the valids.
- Push order: when both channels push in the same cycle, the LSU entry is written at tail and the ALU entry at tail+1. The LSU entry is older.
- count update: `count_next = count + pushes - pop`, where pushes is 0..2 and pop is 0..1.
- Address 0 entries are queued and written like any other. Suppressing writes to r0 is the register file's job.
- Duplicate addresses in the FIFO are all written in order. Forwarding returns the youngest one.
- Forwarding:
  - Combinational search over occupied entries only.
  - The head entry being written this cycle is included.
  - Entries being pushed this cycle are not included.
- Reset (asynchronous): pointers and count go to 0 and storage is cleared. Outputs take their idle values immediately: `Write`=0, `Write_ADDR`=0, `DIN`=0, `empty`=1, `count`=0, fwd hits 0, fwd data 0, both ready = 1 (free = DEPTH). Any in-flight entries are lost.

## Timing
- Push-to-write latency: an entry accepted at edge N appears on `Write` during the cycle after edge N. The register file captures it at edge N+1.
- Back-to-back: one write per cycle, with no bubble while the queue is non-empty.
- Full (count == DEPTH, so free = 1): only the LSU may push, and it pushes while the head pops.
- Simultaneous 2 pushes + 1 pop: count increases by 1.
- Throughput: sustained input above 1 per cycle fills the FIFO; after that the ALU stalls until the LSU is idle.
- Forwarding outputs are valid in the same cycle as the `Read_ADDR_*` change. There is no added latency.

## Test plan
- **Reset and idle:** `rst`=1 mid-run with 3 entries queued → next cycle `Write`=0, `count`=0, `empty`=1, both ready high; no further writes occur.
- **Single push:** ALU pushes addr 3, data 0x4 at edge N → `Write`=1, `Write_ADDR`=3, `DIN`=0x4 for exactly one cycle; `mem[3]`=0x4 afterward.
- **Dual push ordering:** same cycle, LSU (1, 0x2) and ALU (2, 0x3) into an empty queue → writes appear on consecutive cycles, addr 1 then addr 2.
- **Full arbitration:** hold both valid every cycle with DEPTH=4 → count reaches 4. Then `alu_ready`=0 and `lsu_ready`=1, count stays at 4, and LSU data drains in order.
- **Forwarding:**
  - Queue (5, 0xA) then (5, 0xB), with `Read_ADDR_1`=5, `Read_ADDR_2`=6 → `fwd_hit_1`=1, `fwd_data_1`=0xB, `fwd_hit_2`=0, `fwd_data_2`=0.
  - After both drain, `fwd_hit_1`=0.
- **Wrap-around:** push 10 entries (addr i, data i+1) with gaps → all 10 writes occur in order with correct data, and pointers wrap without loss.
